status_register: RTL and testbench

STATUS_REGISTER -- requirements
Module: status_register

---
 rtl/status_register_pkg.sv | 45 ++++
 rtl/status_register.sv | 135 +++++++++++++
 tb/tb_status_register.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/status_register_pkg.sv
// Shared definitions for the 6502-style processor status register:
// flag bit positions, default reset image, stored-flag struct and irq_mask FSM states.
package status_register_pkg;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_I = 2;
    localparam int unsigned FLAG_D = 3;
    localparam int unsigned FLAG_B = 4;
    localparam int unsigned FLAG_U = 5;
    localparam int unsigned FLAG_V = 6;
    localparam int unsigned FLAG_N = 7;

    localparam logic [7:0] RESET_P_DEFAULT = 8'h04;

    typedef enum logic {
        IRQ_SYNC = 1'b0,
        IRQ_PEND = 1'b1
    } irq_state_e;

    // Only six flags are stored; B and U exist only in the pushed image.
    typedef struct packed {
        logic n;
        logic v;
        logic d;
        logic i;
        logic z;
        logic c;
    } flags_t;

    function automatic logic [7:0] flags_to_push(input flags_t f, input logic brk);
        logic [7:0] p;
        p         = 8'h00;
        p[FLAG_C] = f.c;
        p[FLAG_Z] = f.z;
        p[FLAG_I] = f.i;
        p[FLAG_D] = f.d;
        p[FLAG_B] = brk;
        p[FLAG_U] = 1'b1;
        p[FLAG_V] = f.v;
        p[FLAG_N] = f.n;
        return p;
    endfunction

endpackage

// File: rtl/status_register.sv
// Processor status register: stored N/V/D/I/Z/C flags with prioritised update
// sources, push-image generation and a one-instruction-delayed interrupt mask.
module status_register
    import status_register_pkg::*;
#(
    parameter logic [7:0] RESET_P = RESET_P_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_ovflw,
    input  logic       upd_nz,
    input  logic       upd_c,
    input  logic       upd_v,
    input  logic       bit_en,
    input  logic       ld_p,
    input  logic [7:0] db_in,
    input  logic       set_c,
    input  logic       clr_c,
    input  logic       set_i,
    input  logic       clr_i,
    input  logic       set_d,
    input  logic       clr_d,
    input  logic       clr_v,
    input  logic       instr_done,
    input  logic       brk_push,
    output logic [7:0] p_push,
    output logic       flag_c,
    output logic       flag_z,
    output logic       flag_i,
    output logic       flag_d,
    output logic       flag_v,
    output logic       flag_n,
    output logic       irq_mask
);

    localparam flags_t RESET_FLAGS = '{
        n: RESET_P[FLAG_N],
        v: RESET_P[FLAG_V],
        d: RESET_P[FLAG_D],
        i: RESET_P[FLAG_I],
        z: RESET_P[FLAG_Z],
        c: RESET_P[FLAG_C]
    };

    flags_t     flags_q, flags_d;
    irq_state_e state_q, state_d;
    logic       irq_mask_q, irq_mask_d;
    logic       alu_zero;
    logic       i_changed;
    logic       hw_irq_entry;
    logic       unused_db_bits;

    assign alu_zero       = (alu_result == 8'h00);
    assign unused_db_bits = ^db_in[FLAG_U:FLAG_B];

    // Per-flag priority: ld_p, then BIT, then the ALU enables, then set/clear strobes.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        flags_d = flags_q;
        if (ld_p) begin
            flags_d.n = db_in[FLAG_N];
            flags_d.v = db_in[FLAG_V];
            flags_d.d = db_in[FLAG_D];
            flags_d.i = db_in[FLAG_I];
            flags_d.z = db_in[FLAG_Z];
            flags_d.c = db_in[FLAG_C];
        end else begin
            if (bit_en) begin
                flags_d.n = db_in[FLAG_N];
                flags_d.v = db_in[FLAG_V];
                flags_d.z = alu_zero;
            end else begin
                if (upd_nz) begin
                    flags_d.n = alu_result[7];
                    flags_d.z = alu_zero;
                end
                if (upd_v)      flags_d.v = alu_ovflw;
                else if (clr_v) flags_d.v = 1'b0;
            end

            if (upd_c)                flags_d.c = alu_carry;
            else if (set_c && !clr_c) flags_d.c = 1'b1;
            else if (clr_c && !set_c) flags_d.c = 1'b0;

            if (set_i && !clr_i)      flags_d.i = 1'b1;
            else if (clr_i && !set_i) flags_d.i = 1'b0;

            if (set_d && !clr_d)      flags_d.d = 1'b1;
            else if (clr_d && !set_d) flags_d.d = 1'b0;
        end
    end

    // Interrupt entry masks immediately; software I changes wait for the next instruction boundary.
    assign i_changed    = (flags_d.i != flags_q.i);
    assign hw_irq_entry = set_i && !clr_i && !brk_push && !ld_p;

    always_comb begin
        state_d    = state_q;
        irq_mask_d = irq_mask_q;
        if (hw_irq_entry) begin
            irq_mask_d = 1'b1;
            state_d    = IRQ_SYNC;
        end else if (i_changed) begin
            state_d    = IRQ_PEND;
        end else if (state_q == IRQ_PEND && instr_done) begin
            irq_mask_d = flags_q.i;
            state_d    = IRQ_SYNC;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            flags_q    <= RESET_FLAGS;
            state_q    <= IRQ_SYNC;
            irq_mask_q <= RESET_P[FLAG_I];
        end else begin
            flags_q    <= flags_d;
            state_q    <= state_d;
            irq_mask_q <= irq_mask_d;
        end
    end

    assign p_push   = flags_to_push(flags_q, brk_push);
    assign flag_c   = flags_q.c;
    assign flag_z   = flags_q.z;
    assign flag_i   = flags_q.i;
    assign flag_d   = flags_q.d;
    assign flag_v   = flags_q.v;
    assign flag_n   = flags_q.n;
    assign irq_mask = irq_mask_q;

endmodule

// File: tb/tb_status_register.sv
// Directed bench for status_register: stimulus pushes hand-computed expectations
// into a scoreboard queue, a monitor compares them one cycle after each edge.
module tb_status_register;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] alu_result;
    logic       alu_carry, alu_ovflw;
    logic       upd_nz, upd_c, upd_v, bit_en, ld_p;
    logic [7:0] db_in;
    logic       set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v;
    logic       instr_done, brk_push;
    logic [7:0] p_push;
    logic       flag_c, flag_z, flag_i, flag_d, flag_v, flag_n, irq_mask;

    always #5 clk = ~clk;

    status_register dut (
        .clk        (clk),
        .rst        (rst),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .alu_ovflw  (alu_ovflw),
        .upd_nz     (upd_nz),
        .upd_c      (upd_c),
        .upd_v      (upd_v),
        .bit_en     (bit_en),
        .ld_p       (ld_p),
        .db_in      (db_in),
        .set_c      (set_c),
        .clr_c      (clr_c),
        .set_i      (set_i),
        .clr_i      (clr_i),
        .set_d      (set_d),
        .clr_d      (clr_d),
        .clr_v      (clr_v),
        .instr_done (instr_done),
        .brk_push   (brk_push),
        .p_push     (p_push),
        .flag_c     (flag_c),
        .flag_z     (flag_z),
        .flag_i     (flag_i),
        .flag_d     (flag_d),
        .flag_v     (flag_v),
        .flag_n     (flag_n),
        .irq_mask   (irq_mask)
    );

    typedef struct {
        logic       rst, ld_p, bit_en, upd_nz, upd_c, upd_v;
        logic       set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v;
        logic       instr_done, brk_push, alu_carry, alu_ovflw;
        logic [7:0] alu_result, db_in;
    } stim_t;

    typedef struct {
        int         due;
        string      name;
        logic [5:0] flags;   // {N,V,D,I,Z,C}
        logic [7:0] push;
        logic       mask;
    } exp_t;

    exp_t  sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    stim_t s;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            check({e.name, ".due"}, cyc, e.due);
            check({e.name, ".flags"},
                  {26'd0, flag_n, flag_v, flag_d, flag_i, flag_z, flag_c}, {26'd0, e.flags});
            check({e.name, ".p_push"}, {24'd0, p_push}, {24'd0, e.push});
            check({e.name, ".irq_mask"}, {31'd0, irq_mask}, {31'd0, e.mask});
        end
    end

    function automatic stim_t idle(input logic brk);
        stim_t t;
        t.rst = 1'b0;   t.ld_p = 1'b0;  t.bit_en = 1'b0; t.upd_nz = 1'b0;
        t.upd_c = 1'b0; t.upd_v = 1'b0; t.set_c = 1'b0;  t.clr_c = 1'b0;
        t.set_i = 1'b0; t.clr_i = 1'b0; t.set_d = 1'b0;  t.clr_d = 1'b0;
        t.clr_v = 1'b0; t.instr_done = 1'b0; t.brk_push = brk;
        t.alu_carry = 1'b0; t.alu_ovflw = 1'b0;
        t.alu_result = 8'h00; t.db_in = 8'h00;
        return t;
    endfunction

    task automatic step(input stim_t t, input string name, input bit chk,
                        input logic [5:0] f, input logic [7:0] p, input logic m);
        exp_t e;
        @(negedge clk);
        rst = t.rst;       ld_p = t.ld_p;     bit_en = t.bit_en;
        upd_nz = t.upd_nz; upd_c = t.upd_c;   upd_v = t.upd_v;
        set_c = t.set_c;   clr_c = t.clr_c;   set_i = t.set_i;
        clr_i = t.clr_i;   set_d = t.set_d;   clr_d = t.clr_d;
        clr_v = t.clr_v;   instr_done = t.instr_done;
        brk_push = t.brk_push;
        alu_carry = t.alu_carry; alu_ovflw = t.alu_ovflw;
        alu_result = t.alu_result; db_in = t.db_in;
        if (chk) begin
            e.due = cyc + 1; e.name = name; e.flags = f; e.push = p; e.mask = m;
            sb_q.push_back(e);
        end
    endtask

    initial begin
        s = idle(1'b0);
        s.rst = 1'b1;
        rst = 1'b1; ld_p = 1'b0; bit_en = 1'b0; upd_nz = 1'b0; upd_c = 1'b0; upd_v = 1'b0;
        set_c = 1'b0; clr_c = 1'b0; set_i = 1'b0; clr_i = 1'b0; set_d = 1'b0; clr_d = 1'b0;
        clr_v = 1'b0; instr_done = 1'b0; brk_push = 1'b0; alu_carry = 1'b0; alu_ovflw = 1'b0;
        alu_result = 8'h00; db_in = 8'h00;

        step(s, "reset0", 1'b0, 6'b000000, 8'h00, 1'b0);
        step(s, "reset", 1'b1, 6'b000100, 8'h24, 1'b1);

        s = idle(1'b0); s.alu_result = 8'h00; s.alu_carry = 1'b1; s.alu_ovflw = 1'b1;
        s.upd_nz = 1'b1; s.upd_c = 1'b1; s.upd_v = 1'b1;
        step(s, "alu_all", 1'b1, 6'b010111, 8'h67, 1'b1);

        s = idle(1'b0); s.upd_nz = 1'b1; s.alu_result = 8'h80;
        step(s, "alu_neg", 1'b1, 6'b110101, 8'hE5, 1'b1);

        s = idle(1'b0); s.upd_c = 1'b1; s.alu_carry = 1'b0; s.set_c = 1'b1;
        step(s, "updc_over_sec", 1'b1, 6'b110100, 8'hE4, 1'b1);

        s = idle(1'b0); s.set_c = 1'b1;
        step(s, "sec", 1'b1, 6'b110101, 8'hE5, 1'b1);

        s = idle(1'b0); s.set_c = 1'b1; s.clr_c = 1'b1; s.clr_v = 1'b1;
        step(s, "c_conflict_clv", 1'b1, 6'b100101, 8'hA5, 1'b1);

        s = idle(1'b1); s.ld_p = 1'b1; s.db_in = 8'hFF; s.upd_nz = 1'b1; s.alu_result = 8'h01;
        step(s, "plp_ff_brk1", 1'b1, 6'b111111, 8'hFF, 1'b1);

        s = idle(1'b0);
        step(s, "plp_ff_brk0", 1'b1, 6'b111111, 8'hEF, 1'b1);

        s = idle(1'b0); s.ld_p = 1'b1; s.db_in = 8'h00;
        step(s, "plp_00_pend", 1'b1, 6'b000000, 8'h20, 1'b1);

        s = idle(1'b0); s.instr_done = 1'b1;
        step(s, "plp_00_done", 1'b1, 6'b000000, 8'h20, 1'b0);

        s = idle(1'b0); s.set_c = 1'b1;
        step(s, "sec2", 1'b1, 6'b000001, 8'h21, 1'b0);

        s = idle(1'b0); s.bit_en = 1'b1; s.db_in = 8'hC0; s.alu_result = 8'h00;
        s.upd_v = 1'b1; s.alu_ovflw = 1'b0;
        step(s, "bit", 1'b1, 6'b110011, 8'hE3, 1'b0);

        s = idle(1'b1); s.set_i = 1'b1;
        step(s, "sei_pend", 1'b1, 6'b110111, 8'hF7, 1'b0);

        s = idle(1'b1); s.instr_done = 1'b1;
        step(s, "sei_done", 1'b1, 6'b110111, 8'hF7, 1'b1);

        s = idle(1'b1); s.clr_i = 1'b1; s.instr_done = 1'b1;
        step(s, "cli_with_done", 1'b1, 6'b110011, 8'hF3, 1'b1);

        s = idle(1'b1);
        step(s, "cli_wait", 1'b1, 6'b110011, 8'hF3, 1'b1);

        s = idle(1'b1); s.set_i = 1'b1;
        step(s, "sei_in_pend", 1'b1, 6'b110111, 8'hF7, 1'b1);

        s = idle(1'b1); s.instr_done = 1'b1;
        step(s, "sei_in_pend_done", 1'b1, 6'b110111, 8'hF7, 1'b1);

        s = idle(1'b1); s.clr_i = 1'b1;
        step(s, "cli2", 1'b1, 6'b110011, 8'hF3, 1'b1);

        s = idle(1'b1); s.set_d = 1'b1;
        step(s, "sed_in_pend", 1'b1, 6'b111011, 8'hFB, 1'b1);

        s = idle(1'b1); s.instr_done = 1'b1;
        step(s, "cli2_done", 1'b1, 6'b111011, 8'hFB, 1'b0);

        s = idle(1'b1); s.set_d = 1'b1; s.clr_d = 1'b1;
        step(s, "d_conflict", 1'b1, 6'b111011, 8'hFB, 1'b0);

        s = idle(1'b0); s.set_i = 1'b1;
        step(s, "hw_irq_entry", 1'b1, 6'b111111, 8'hEF, 1'b1);

        s = idle(1'b0); s.clr_i = 1'b1;
        step(s, "cli3_pend", 1'b1, 6'b111011, 8'hEB, 1'b1);

        s = idle(1'b0); s.rst = 1'b1; s.set_c = 1'b1; s.ld_p = 1'b1; s.db_in = 8'hFF;
        step(s, "reset_mid_pend", 1'b1, 6'b000100, 8'h24, 1'b1);

        s = idle(1'b0); s.instr_done = 1'b1;
        step(s, "after_reset_done", 1'b1, 6'b000100, 8'h24, 1'b1);

        s = idle(1'b1); s.clr_i = 1'b1;
        step(s, "cli4_pend", 1'b1, 6'b000000, 8'h30, 1'b1);

        s = idle(1'b1); s.instr_done = 1'b1;
        step(s, "cli4_done", 1'b1, 6'b000000, 8'h30, 1'b0);

        s = idle(1'b0);
        step(s, "final_idle", 1'b0, 6'b000000, 8'h00, 1'b0);

        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
        check("scoreboard_drain", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
